// File: rtl/audio_dac_serializer_if.sv
// audio_dac_serializer_if: stereo sample handshake into the DAC serializer.
// Master drives valid/left/right; slave returns ready.
interface audio_dac_serializer_if;
  logic        s_valid;
  logic        s_ready;
  logic [15:0] s_left;
  logic [15:0] s_right;

  modport master (
    output s_valid,
    output s_left,
    output s_right,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_left,
    input  s_right,
    output s_ready
  );
endinterface

// File: rtl/audio_dac_serializer.sv
// audio_dac_serializer: sample FIFO + left-justified stereo serializer, USB-mode codec.
// Define AUDIO_DAC_SERIALIZER_DEBUG_TAP_EN to expose debug_daclrck/debug_dacdat.
module audio_dac_serializer #(
  parameter int FRAME_LEN  = 250,
  parameter int FIFO_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset_n,
  audio_dac_serializer_if.slave s,
  output logic       aud_daclrck,
  output logic       aud_dacdat,
  output logic       frame_tick,
  output logic [7:0] underrun_count
`ifdef AUDIO_DAC_SERIALIZER_DEBUG_TAP_EN
  ,
  output logic       debug_daclrck,
  output logic       debug_dacdat
`endif
);
  localparam int KW   = $clog2(FRAME_LEN);
  localparam int AW   = $clog2(FIFO_DEPTH);
  localparam int HALF = FRAME_LEN / 2;
  localparam logic [KW-1:0] K_LAST = KW'(FRAME_LEN - 1);
  localparam logic [KW-1:0] K_HALF = KW'(HALF);
  localparam logic [KW-1:0] K_BITS = KW'(16);

  typedef enum logic {
    ST_IDLE,
    ST_RUN
  } state_t;

  state_t        state;
  state_t        state_nx;
  logic [KW-1:0] k;
  logic [KW-1:0] k_nx;
  logic [KW-1:0] k_r;
  logic [AW:0]   wr_ptr;
  logic [AW:0]   rd_ptr;
  logic [31:0]   mem [FIFO_DEPTH];
  logic [31:0]   smp;
  logic [31:0]   smp_nx;
  logic [15:0]   smp_l;
  logic [15:0]   smp_r;
  logic [3:0]    idx_l;
  logic [3:0]    idx_r;
  logic          running;
  logic          empty;
  logic          full;
  logic          push;
  logic          frame_end;
  logic          pop;
  logic          lrck_nx;
  logic          dat_nx;

  always_ff @(posedge clk) begin
    if (!reset_n) state <= ST_IDLE;
    else          state <= state_nx;
  end

  // One idle cycle after reset raises ready before the first frame starts.
  always_comb begin
    state_nx = state;
    unique case (state)
      ST_IDLE: state_nx = ST_RUN;
      ST_RUN:  state_nx = ST_RUN;
      default: state_nx = ST_IDLE;
    endcase
  end

  assign running   = (state == ST_RUN);
  assign empty     = (wr_ptr == rd_ptr);
  assign full      = (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]) &&
                     (wr_ptr[AW] != rd_ptr[AW]);
  assign s.s_ready = running && !full;
  assign push      = s.s_valid && s.s_ready;
  assign frame_end = running && (k == K_LAST);
  assign pop       = frame_end && !empty;

  always_comb begin
    k_nx = k;
    if (running) k_nx = frame_end ? '0 : k + KW'(1);
  end

  // On underrun the held sample is simply kept for another frame.
  assign smp_nx = pop ? mem[rd_ptr[AW-1:0]] : smp;
  assign smp_l  = smp_nx[31:16];
  assign smp_r  = smp_nx[15:0];
  assign k_r    = k_nx - K_HALF;
  assign idx_l  = 4'd15 - k_nx[3:0];
  assign idx_r  = 4'd15 - k_r[3:0];

  always_comb begin
    lrck_nx = (k_nx < K_HALF);
    dat_nx  = 1'b0;
    if (k_nx < K_BITS)
      dat_nx = smp_l[idx_l];
    else if (k_nx >= K_HALF && k_r < K_BITS)
      dat_nx = smp_r[idx_r];
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      k              <= K_LAST;
      wr_ptr         <= '0;
      rd_ptr         <= '0;
      smp            <= '0;
      underrun_count <= '0;
      aud_daclrck    <= 1'b0;
      aud_dacdat     <= 1'b0;
      frame_tick     <= 1'b0;
    end else begin
      k           <= k_nx;
      smp         <= smp_nx;
      aud_daclrck <= lrck_nx;
      aud_dacdat  <= dat_nx;
      frame_tick  <= frame_end;
      if (push) wr_ptr <= wr_ptr + (AW+1)'(1);
      if (pop)  rd_ptr <= rd_ptr + (AW+1)'(1);
      if (frame_end && empty && underrun_count != 8'hFF)
        underrun_count <= underrun_count + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr[AW-1:0]] <= {s.s_left, s.s_right};
  end

`ifdef AUDIO_DAC_SERIALIZER_DEBUG_TAP_EN
  assign debug_daclrck = aud_daclrck;
  assign debug_dacdat  = aud_dacdat;
`endif
endmodule

// File: tb/tb_audio_dac_serializer.sv
// tb_audio_dac_serializer: random + directed checks of the DAC serializer
// against a queue-based frame model.
`timescale 1ns/1ps
module tb_audio_dac_serializer;
  localparam int FL    = 250;
  localparam int HALF  = FL / 2;
  localparam int DEPTH = 4;

  logic       clk = 1'b0;
  logic       reset_n = 1'b0;
  logic       aud_daclrck;
  logic       aud_dacdat;
  logic       frame_tick;
  logic [7:0] underrun_count;
`ifdef AUDIO_DAC_SERIALIZER_DEBUG_TAP_EN
  logic       debug_daclrck;
  logic       debug_dacdat;
`endif
  int checks = 0;
  int failures = 0;

  audio_dac_serializer_if bus();

  always #5 clk = ~clk;

  audio_dac_serializer #(.FRAME_LEN(FL), .FIFO_DEPTH(DEPTH)) dut (
    .clk(clk),
    .reset_n(reset_n),
    .s(bus),
    .aud_daclrck(aud_daclrck),
    .aud_dacdat(aud_dacdat),
    .frame_tick(frame_tick),
    .underrun_count(underrun_count)
`ifdef AUDIO_DAC_SERIALIZER_DEBUG_TAP_EN
    ,
    .debug_daclrck(debug_daclrck),
    .debug_dacdat(debug_dacdat)
`endif
  );

  // Reference model: a sample queue, a frame position and a held sample.
  logic [31:0] q[$];
  logic [31:0] m_cur = '0;
  int m_st = 0;
  int m_pos = FL - 1;
  int m_urc = 0;
  logic e_lrck = 0, e_dat = 0, e_tick = 0, e_ready = 0;
  bit m_acc;
  bit mon_en = 0;

  always @(posedge clk) begin
    m_acc = (bus.s_valid === 1'b1) && e_ready;
    if (!reset_n) begin
      q.delete();
      m_cur = '0; m_st = 0; m_pos = FL - 1; m_urc = 0;
      e_lrck = 0; e_dat = 0; e_tick = 0; e_ready = 0;
    end else begin
      e_tick = 0;
      if (m_st == 0) m_st = 1;
      else begin
        m_pos = (m_st == 1) ? 0 : (m_pos + 1) % FL;
        m_st = 2;
        if (m_pos == 0) begin
          e_tick = 1;
          if (q.size() > 0) m_cur = q.pop_front();
          else if (m_urc < 255) m_urc++;
        end
      end
      if (m_acc) q.push_back({bus.s_left, bus.s_right});
      e_lrck = (m_st == 2) && (m_pos < HALF);
      e_dat = 0;
      if (m_st == 2 && m_pos < 16)
        e_dat = m_cur[31 - m_pos];
      else if (m_st == 2 && m_pos >= HALF && m_pos < HALF + 16)
        e_dat = m_cur[15 - (m_pos - HALF)];
      e_ready = (m_st >= 1) && (q.size() < DEPTH);
    end
  end

  always @(negedge clk) begin
    if (mon_en) begin
      checks++;
      if ({aud_daclrck, aud_dacdat, frame_tick, bus.s_ready}
          !== {e_lrck, e_dat, e_tick, e_ready}
          || underrun_count !== m_urc[7:0]) begin
        failures++;
        if (failures <= 20)
          $display("FAIL scoreboard t=%0t lrck=%b/%b dat=%b/%b tick=%b/%b rdy=%b/%b urc=%0d/%0d",
            $time, aud_daclrck, e_lrck, aud_dacdat, e_dat, frame_tick, e_tick,
            bus.s_ready, e_ready, underrun_count, m_urc);
      end
`ifdef AUDIO_DAC_SERIALIZER_DEBUG_TAP_EN
      checks++;
      if ({debug_daclrck, debug_dacdat} !== {aud_daclrck, aud_dacdat}) begin
        failures++;
        $display("FAIL debug_tap got=%b%b want=%b%b",
          debug_daclrck, debug_dacdat, aud_daclrck, aud_dacdat);
      end
`endif
    end
  end

  task automatic do_reset();
    @(negedge clk);
    reset_n = 0;
    bus.s_valid = 0;
    repeat (3) @(negedge clk);
    reset_n = 1;
  endtask

  task automatic wait_pos(input int p);
    int n;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(m_st == 2 && m_pos == p) && n < 2 * FL);
    checks++;
    if (n >= 2 * FL) begin
      failures++;
      $display("FAIL wait_pos got=timeout want=pos%0d", p);
    end
  endtask

  task automatic push(input logic [15:0] l, input logic [15:0] r);
    int n;
    n = 0;
    bus.s_valid = 1; bus.s_left = l; bus.s_right = r;
    while (bus.s_ready !== 1'b1 && n < 4 * FL) begin
      @(negedge clk);
      n++;
    end
    @(negedge clk);
    bus.s_valid = 0;
    checks++;
    if (n >= 4 * FL) begin
      failures++;
      $display("FAIL push_timeout got=%0d want<%0d", n, 4 * FL);
    end
  endtask

  task automatic grab_frame(output logic [15:0] l, output logic [15:0] r,
                            output logic [FL-1:0] bits);
    int n;
    n = 0;
    l = 'x; r = 'x; bits = 'x;
    do begin
      @(negedge clk);
      n++;
    end while (frame_tick !== 1'b1 && n < 2 * FL);
    for (int j = 0; j < FL; j++) begin
      bits[j] = aud_dacdat;
      if (j < 16) l[15 - j] = aud_dacdat;
      if (j >= HALF && j < HALF + 16) r[15 - (j - HALF)] = aud_dacdat;
      if (j < FL - 1) @(negedge clk);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    reset_n = 0;
    bus.s_valid = 1; bus.s_left = 16'hFFFF; bus.s_right = 16'hFFFF;
    repeat (3) @(negedge clk);
    mon_en = 1;
    checks++;
    if ({aud_daclrck, aud_dacdat, frame_tick, bus.s_ready} !== 4'b0000
        || underrun_count !== 8'd0) begin
      failures++;
      $display("FAIL reset_state got=%b%b%b%b/%0d want=0000/0",
        aud_daclrck, aud_dacdat, frame_tick, bus.s_ready, underrun_count);
    end
    bus.s_valid = 0;
    reset_n = 1;
    @(negedge clk);
    checks++;
    if (bus.s_ready !== 1'b1 || frame_tick !== 1'b0 || aud_daclrck !== 1'b0) begin
      failures++;
      $display("FAIL release_edge1 got rdy=%b tick=%b lrck=%b want 1 0 0",
        bus.s_ready, frame_tick, aud_daclrck);
    end
    @(negedge clk);
    checks++;
    if (frame_tick !== 1'b1 || aud_daclrck !== 1'b1 || underrun_count !== 8'd1) begin
      failures++;
      $display("FAIL release_edge2 got tick=%b lrck=%b urc=%0d want 1 1 1",
        frame_tick, aud_daclrck, underrun_count);
    end
  endtask

  task automatic test_idle();
    int hi, bad_lr, ones, ticks;
    logic [7:0] u;
    do_reset();
    repeat (2) @(negedge clk);
    for (int f = 0; f < 3; f++) begin
      hi = 0; bad_lr = 0; ones = 0; ticks = 0;
      u = underrun_count;
      for (int j = 0; j < FL; j++) begin
        if (j > 0) @(negedge clk);
        if (aud_daclrck === 1'b1) hi++;
        if (aud_daclrck !== (j < HALF)) bad_lr++;
        if (aud_dacdat !== 1'b0) ones++;
        if (frame_tick === 1'b1) ticks += (j == 0) ? 1 : 100;
      end
      @(negedge clk);
      checks++;
      if (u !== 8'(f + 1)) begin
        failures++;
        $display("FAIL idle_urc got=%0d want=%0d", u, f + 1);
      end
      checks++;
      if (hi != HALF || bad_lr != 0) begin
        failures++;
        $display("FAIL idle_lrck got hi=%0d bad=%0d want hi=%0d bad=0", hi, bad_lr, HALF);
      end
      checks++;
      if (ones != 0) begin
        failures++;
        $display("FAIL idle_dat got=%0d ones want=0", ones);
      end
      checks++;
      if (ticks != 1) begin
        failures++;
        $display("FAIL idle_tick got=%0d want=1", ticks);
      end
    end
  endtask

  task automatic test_pattern();
    logic [15:0] l, r;
    logic [FL-1:0] bits, want;
    logic [15:0] wl, wr;
    wl = 16'hA5C3; wr = 16'h8001;
    want = '0;
    for (int i = 0; i < 16; i++) begin
      want[i] = wl[15 - i];
      want[HALF + i] = wr[15 - i];
    end
    wait_pos(5);
    push(wl, wr);
    grab_frame(l, r, bits);
    checks++;
    if (l !== wl) begin
      failures++;
      $display("FAIL pattern_left got=%h want=%h", l, wl);
    end
    checks++;
    if (r !== wr) begin
      failures++;
      $display("FAIL pattern_right got=%h want=%h", r, wr);
    end
    checks++;
    if (bits !== want) begin
      failures++;
      $display("FAIL pattern_frame got=%h want=%h", bits, want);
    end
  endtask

  task automatic test_fill();
    logic [31:0] smp[6];
    logic [15:0] l, r;
    logic [FL-1:0] bits;
    int idx, dropped, n;
    bit rdy;
    for (int i = 0; i < 6; i++)
      smp[i] = {4'(i), 12'($urandom), 16'($urandom)};
    do_reset();
    @(negedge clk);
    idx = 0; dropped = -1; n = 0;
    bus.s_valid = 1;
    while (idx < 6 && n < 6 * FL) begin
      bus.s_left = smp[idx][31:16];
      bus.s_right = smp[idx][15:0];
      rdy = (bus.s_ready === 1'b1);
      if (!rdy && dropped < 0) dropped = idx;
      @(negedge clk);
      if (rdy) idx++;
      n++;
    end
    bus.s_valid = 0;
    checks++;
    if (dropped != 4) begin
      failures++;
      $display("FAIL fill_ready_drop got=%0d want=4", dropped);
    end
    checks++;
    if (idx != 6) begin
      failures++;
      $display("FAIL fill_accept got=%0d want=6", idx);
    end
    for (int f = 2; f < 7; f++) begin
      grab_frame(l, r, bits);
      checks++;
      if ({l, r} !== smp[f > 5 ? 5 : f]) begin
        failures++;
        $display("FAIL fill_order f=%0d got=%h want=%h", f, {l, r}, smp[f > 5 ? 5 : f]);
      end
      checks++;
      if (underrun_count !== ((f > 5) ? 8'd2 : 8'd1)) begin
        failures++;
        $display("FAIL fill_urc f=%0d got=%0d want=%0d", f, underrun_count, (f > 5) ? 2 : 1);
      end
    end
  endtask

  task automatic test_coincide();
    logic [31:0] smp[6];
    logic [15:0] l, r;
    logic [FL-1:0] bits;
    int cnt, n;
    for (int i = 0; i < 6; i++)
      smp[i] = {4'(i + 8), 12'($urandom), 16'($urandom)};
    do_reset();
    @(negedge clk);
    push(smp[0][31:16], smp[0][15:0]);
    push(smp[1][31:16], smp[1][15:0]);
    wait_pos(FL - 1);
    bus.s_valid = 1; bus.s_left = smp[2][31:16]; bus.s_right = smp[2][15:0];
    @(negedge clk);
    bus.s_valid = 0;
    checks++;
    if (bus.s_ready !== 1'b1 || frame_tick !== 1'b1) begin
      failures++;
      $display("FAIL coincide_ready got rdy=%b tick=%b want 1 1", bus.s_ready, frame_tick);
    end
    cnt = 0; n = 0;
    bus.s_valid = 1;
    while (bus.s_ready === 1'b1 && n < 10) begin
      bus.s_left = smp[3 + cnt][31:16];
      bus.s_right = smp[3 + cnt][15:0];
      @(negedge clk);
      cnt++;
      n++;
    end
    bus.s_valid = 0;
    checks++;
    if (cnt != 2) begin
      failures++;
      $display("FAIL coincide_space got=%0d want=2", cnt);
    end
    for (int f = 1; f < 5; f++) begin
      grab_frame(l, r, bits);
      checks++;
      if ({l, r} !== smp[f]) begin
        failures++;
        $display("FAIL coincide_order f=%0d got=%h want=%h", f, {l, r}, smp[f]);
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [15:0] l, r;
    logic [FL-1:0] bits;
    do_reset();
    @(negedge clk);
    for (int i = 0; i < 3; i++) push(16'($urandom) | 16'h8000, 16'($urandom) | 16'h0001);
    wait_pos(60);
    reset_n = 0;
    @(negedge clk);
    checks++;
    if ({aud_daclrck, aud_dacdat, frame_tick, bus.s_ready} !== 4'b0000
        || underrun_count !== 8'd0) begin
      failures++;
      $display("FAIL midreset_out got=%b%b%b%b/%0d want=0000/0",
        aud_daclrck, aud_dacdat, frame_tick, bus.s_ready, underrun_count);
    end
    @(negedge clk);
    reset_n = 1;
    grab_frame(l, r, bits);
    checks++;
    if (bits !== '0) begin
      failures++;
      $display("FAIL midreset_sample got=%h want=0", bits);
    end
    checks++;
    if (underrun_count !== 8'd1) begin
      failures++;
      $display("FAIL midreset_urc got=%0d want=1", underrun_count);
    end
  endtask

  task automatic test_random();
    int thr;
    for (int f = 0; f < 10; f++) begin
      thr = $urandom_range(0, 3);
      for (int j = 0; j < FL; j++) begin
        bus.s_valid = ($urandom_range(0, FL - 1) < thr);
        bus.s_left = 16'($urandom);
        bus.s_right = 16'($urandom);
        @(negedge clk);
      end
    end
    bus.s_valid = 0;
    checks++;
    if (underrun_count !== m_urc[7:0]) begin
      failures++;
      $display("FAIL random_urc got=%0d want=%0d", underrun_count, m_urc);
    end
  endtask

  task automatic test_saturate();
    logic [15:0] l, r, wl, wr;
    logic [FL-1:0] bits;
    wl = 16'($urandom) | 16'h0100;
    wr = 16'($urandom) | 16'h0010;
    do_reset();
    repeat (258 * FL) @(negedge clk);
    checks++;
    if (underrun_count !== 8'd255) begin
      failures++;
      $display("FAIL sat_count got=%0d want=255", underrun_count);
    end
    wait_pos(100);
    push(wl, wr);
    grab_frame(l, r, bits);
    checks++;
    if ({l, r} !== {wl, wr}) begin
      failures++;
      $display("FAIL sat_play got=%h want=%h", {l, r}, {wl, wr});
    end
    checks++;
    if (underrun_count !== 8'd255) begin
      failures++;
      $display("FAIL sat_hold got=%0d want=255", underrun_count);
    end
  endtask

  initial begin
    bus.s_valid = 0;
    bus.s_left = '0;
    bus.s_right = '0;
    test_reset();
    test_idle();
    test_pattern();
    test_fill();
    test_coincide();
    test_reset_mid();
    test_random();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
